// File: rtl/rng_pkg.sv
// Shared LFSR constants, arbiter state encoding and the 10-bit XNOR LFSR step
// for the rng_share_arbiter slice (x^10+x^7+x^3+x^2+1, lockup at all-ones).
package rng_pkg;

    localparam int                LFSR_W      = 10;
    localparam logic [LFSR_W-1:0] LFSR_SEED   = 10'h3E7;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 10'h3FF;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[8:0], ~(s[9] ^ s[6] ^ s[2] ^ s[1])};
    endfunction

endpackage

// File: rtl/lfsr10_core.sv
// 10-bit XNOR LFSR register: load beats shift, holds otherwise.
// Latency: new state visible one cycle after i_shift/i_load; no backpressure.
module lfsr10_core
    import rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_shift,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_val,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= i_load_val;
        end else if (i_shift) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/rng_share_arbiter.sv
// Round-robin share of one LFSR among NUM_REQ clients; grant one cycle after a READY request,
// then SHIFTS refill cycles before the next value. Optional reseed port under RNG_SEED_LOAD_EN.
module rng_share_arbiter
    import rng_pkg::*;
#(
    parameter int                NUM_REQ = 4,
    parameter int                SHIFTS  = 10,
    parameter logic [LFSR_W-1:0] SEED    = LFSR_SEED
) (
    input  logic               clock,
    input  logic               reset,
`ifdef RNG_SEED_LOAD_EN
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_in,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [LFSR_W-1:0]  rnd_data,
    output logic               rnd_valid,
    output logic               ready
);

    localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int               CNT_W     = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SHIFTS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W + 1)'(NUM_REQ);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic [LFSR_W-1:0]  r_data;
    logic               r_valid;
    logic               r_ready;

    logic [LFSR_W-1:0]  w_lfsr;
    logic               w_shift;
    logic               w_load;
    logic [LFSR_W-1:0]  w_load_val;
    logic               w_found;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0] w_grant_oh;

`ifdef RNG_SEED_LOAD_EN
    // All-ones would lock the XNOR LFSR, so fall back to the reset seed.
    assign w_load     = seed_load;
    assign w_load_val = (seed_in == LFSR_LOCKUP) ? SEED : seed_in;
`else
    assign w_load     = 1'b0;
    assign w_load_val = SEED;
`endif

    assign w_shift = (r_state == FILL);

    lfsr10_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .i_shift    (w_shift),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_lfsr     (w_lfsr)
    );

    // Search ptr, ptr+1, ... with explicit wrap so non-power-of-2 NUM_REQ never indexes past the end.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_sum      = '0;
        w_grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(i);
            if (w_sum >= NUM_REQ_X) begin
                w_sum = w_sum - NUM_REQ_X;
            end
            if (!w_found && req[w_sum[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[PTR_W-1:0];
            end
        end
        w_grant_oh[w_winner] = 1'b1;
    end

    assign w_ptr_nxt = (w_winner == PTR_LAST) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_grant <= '0;
            r_valid <= 1'b0;
            if (w_load) begin
                r_state <= FILL;
                r_cnt   <= '0;
                r_ready <= 1'b0;
            end else begin
                case (r_state)
                    FILL: begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= READY;
                            r_cnt   <= '0;
                            r_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    READY: begin
                        if (w_found) begin
                            r_grant <= w_grant_oh;
                            r_data  <= w_lfsr;
                            r_valid <= 1'b1;
                            r_ptr   <= w_ptr_nxt;
                            r_state <= FILL;
                            r_cnt   <= '0;
                            r_ready <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign grant     = r_grant;
    assign rnd_data  = r_data;
    assign rnd_valid = r_valid;
    assign ready     = r_ready;

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Self-checking bench for rng_share_arbiter: directed sequences, a grant table and
// randomized requests against a cycle-level behavioural model.
module tb_rng_share_arbiter;

    localparam int          N      = 4;
    localparam int          SH     = 10;
    localparam logic [9:0]  SEED_V = 10'h3E7;
    localparam logic [9:0]  FIRST  = 10'h307;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] grant;
    logic [9:0]   rnd_data;
    logic         rnd_valid;
    logic         ready;
`ifdef RNG_SEED_LOAD_EN
    logic         seed_load = 1'b0;
    logic [9:0]   seed_in   = '0;
`endif

    rng_share_arbiter #(.NUM_REQ(N), .SHIFTS(SH), .SEED(SEED_V)) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef RNG_SEED_LOAD_EN
        .seed_load (seed_load),
        .seed_in   (seed_in),
`endif
        .req       (req),
        .grant     (grant),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .ready     (ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: m_left counts refill shifts still owed before a value may be handed out.
    logic [9:0]   m_lfsr;
    int           m_left;
    int           m_ptr;
    logic [N-1:0] e_grant;
    logic [9:0]   e_data;
    logic         e_valid;
    logic         e_ready;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp_grant;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [9:0] poly_step(input logic [9:0] s);
        logic fb;
        fb = ~(s[9] ^ s[6] ^ s[2] ^ s[1]);
        return {s[8:0], fb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = SEED_V;
        m_left  = SH;
        m_ptr   = 0;
        e_grant = '0;
        e_data  = '0;
        e_valid = 1'b0;
        e_ready = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        e_grant = '0;
        e_valid = 1'b0;
        if (reset) begin
            model_reset();
            return;
        end
`ifdef RNG_SEED_LOAD_EN
        if (seed_load) begin
            m_lfsr  = (seed_in == 10'h3FF) ? SEED_V : seed_in;
            m_left  = SH;
            e_ready = 1'b0;
            return;
        end
`endif
        if (m_left > 0) begin
            m_lfsr = poly_step(m_lfsr);
            m_left--;
        end else if (req != 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            e_grant    = '0;
            e_grant[w] = 1'b1;
            e_data     = m_lfsr;
            e_valid    = 1'b1;
            m_ptr      = (w + 1) % N;
            m_left     = SH;
        end
        e_ready = (m_left == 0);
    endtask

    task automatic check_outputs();
        check("grant", grant, e_grant);
        check("rnd_valid", rnd_valid, e_valid);
        check("rnd_data", rnd_data, e_data);
        check("ready", ready, e_ready);
        check("onehot", ($countones(grant) <= 1), 1);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 50) begin
            step();
            n++;
        end
        check("ready_timeout", ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int gcyc[$];
        logic [N-1:0] gval[$];

        tbl[0] = '{4'b0001, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010};
        tbl[2] = '{4'b0011, 4'b0001};
        tbl[3] = '{4'b0011, 4'b0010};
        tbl[4] = '{4'b1000, 4'b1000};
        tbl[5] = '{4'b1010, 4'b0010};
        tbl[6] = '{4'b0101, 4'b0100};
        tbl[7] = '{4'b0111, 4'b0001};

        #1;
        // Reset state, fill length and first value.
        do_reset();
        wait_ready(n);
        check("fill_len", n, SH);
        repeat (3) step();
        req = 4'b0001;
        step();
        check("t1_grant", grant, 4'b0001);
        check("t1_data", rnd_data, FIRST);
        check("t1_valid", rnd_valid, 1);
        req = '0;
        step();
        check("t1_pulse", rnd_valid, 0);
        check("t1_hold", rnd_data, FIRST);

        // Reset five cycles into FILL clears outputs at once and restarts the sequence.
        repeat (4) step();
        do_reset();
        check("t4_data_zero", rnd_data, 0);
        wait_ready(n);
        check("t4_fill_len", n, SH);
        req = 4'b0001;
        step();
        check("t4_data", rnd_data, FIRST);
        req = '0;

        // Long idle in READY.
        do_reset();
        wait_ready(n);
        bad = 0;
        repeat (200) begin
            step();
            if (!ready || rnd_valid) bad++;
        end
        check("t5_idle", bad, 0);
        req = 4'b0001;
        step();
        check("t5_data", rnd_data, FIRST);
        req = '0;

        // Continuous full request: rotation and SHIFTS+1 period.
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (rnd_valid) begin
                gcyc.push_back(c);
                gval.push_back(grant);
            end
        end
        req = '0;
        check("t2_count", gcyc.size(), 5);
        for (int k = 0; k < gcyc.size() && k < 5; k++) begin
            check("t2_cycle", gcyc[k], (SH + 1) * (k + 1));
            check("t2_grant", gval[k], 4'b0001 << (k % N));
        end

        // Grant table with round-robin wrap cases.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wait_ready(n);
            req = tbl[i].req;
            step();
            check("tbl_grant", grant, tbl[i].exp_grant);
            req = '0;
        end

`ifdef RNG_SEED_LOAD_EN
        // Seed load with lockup value beats a simultaneous grant.
        do_reset();
        wait_ready(n);
        req       = 4'b0001;
        seed_load = 1'b1;
        seed_in   = 10'h3FF;
        step();
        check("t6_no_grant", rnd_valid, 0);
        seed_load = 1'b0;
        req       = '0;
        wait_ready(n);
        check("t6_fill_len", n, SH);
        req = 4'b0001;
        step();
        check("t6_data", rnd_data, FIRST);
        req = '0;
`endif

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        repeat (3000) begin
            req = N'($urandom);
`ifdef RNG_SEED_LOAD_EN
            seed_load = ($urandom_range(0, 59) == 0);
            seed_in   = 10'($urandom);
`endif
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end
        req = '0;
`ifdef RNG_SEED_LOAD_EN
        seed_load = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
